// File: rtl/pes_arith_pkg.sv
// Shared arithmetic types and op encodings for the pes datapath blocks.
package pes_arith_pkg;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/pes_cla_adder.sv
// Combinational carry-lookahead adder built from 4-bit lookahead groups.
// Bit carries inside a group are fully expanded from the group carry-in;
// groups are chained through their group generate/propagate terms.
module pes_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] sum,
  output logic             c_msb_in,
  output logic             c_out
);
  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = c0;

  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    logic [3:0] gl, pl;
    logic       ci, gg, gp;

    assign gl = g[4*k +: 4];
    assign pl = p[4*k +: 4];
    assign ci = c[4*k];

    assign c[4*k+1] = gl[0] | (pl[0] & ci);
    assign c[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
    assign c[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                    | (pl[2] & pl[1] & pl[0] & ci);

    // Group generate/propagate feed the group-level carry chain.
    assign gg = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
              | (pl[3] & pl[2] & pl[1] & gl[0]);
    assign gp = &pl;
    assign c[4*k+4] = gg | (gp & ci);
  end

  assign sum      = p ^ c[WIDTH-1:0];
  assign c_msb_in = c[WIDTH-1];
  assign c_out    = c[WIDTH];
endmodule

// File: rtl/pes_add_sub_32.sv
// Registered two's-complement adder/subtractor with carry/borrow-in and
// signed-overflow flag. One-cycle latency, one op accepted per cycle.
module pes_add_sub_32
  import pes_arith_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] sum;
  logic             c_msb_in;
  logic             c_out;
  logic [WIDTH-1:0] res_d, res_q;
  logic             ovf_d, ovf_q;

  // Subtract is a + ~b + ~cin: invert operand B and the borrow-in.
  always_comb begin
    b_eff = b;
    c0    = cin;
    if (sub == OP_SUB) begin
      b_eff = ~b;
      c0    = ~cin;
    end
  end

  pes_cla_adder #(.WIDTH(WIDTH)) u_cla (
    .x        (a),
    .y        (b_eff),
    .c0       (c0),
    .sum      (sum),
    .c_msb_in (c_msb_in),
    .c_out    (c_out)
  );

  // Signed overflow: carry into MSB disagrees with carry out of MSB.
  always_comb begin
    res_d = sum;
    ovf_d = c_msb_in ^ c_out;
  end

  // Output register bank, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res = res_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pes_add_sub_32.sv
// Self-checking bench for pes_add_sub_32: directed corner cases plus
// randomized back-to-back ops against a signed-integer reference model.
module tb_pes_add_sub_32;
  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        cin, sub;
  logic [31:0] res;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  pes_add_sub_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .res   (res),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed arithmetic in 64 bits, then wrap and range-check.
  function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms);
    longint sa, sb, full;
    logic   mo;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) full = sa - sb - longint'(mc);
    else    full = sa + sb + longint'(mc);
    mo = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    return {mo, full[31:0]};
  endfunction

  task automatic drive(input logic [31:0] da, input logic [31:0] db,
                       input logic dc, input logic ds);
    a = da; b = db; cin = dc; sub = ds;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({ovf, res} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ovf=%0b res=%h, want ovf=0 res=00000000", ovf, res);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({ovf, res} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_held: got ovf=%0b res=%h, want ovf=0 res=00000000", ovf, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed op: drive at negedge, check one edge later.
  task automatic test_directed(input string nm, input logic [31:0] da, input logic [31:0] db,
                               input logic dc, input logic ds,
                               input logic [31:0] er, input logic eo);
    @(negedge clk);
    drive(da, db, dc, ds);
    @(posedge clk); #1;
    n_checks++;
    if (res !== er || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s: got res=%h ovf=%0b, want res=%h ovf=%0b", nm, res, ovf, er, eo);
    end
  endtask

  task automatic test_mode_change();
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    // Toggle mode between edges; outputs must not move until the next edge.
    sub = 1'b1;
    #2;
    n_checks++;
    if (res !== 32'hFFFF_FFFD || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_hold: got res=%h ovf=%0b, want res=fffffffd ovf=0", res, ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res !== 32'h0000_0001 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_apply: got res=%h ovf=%0b, want res=00000001 ovf=0", res, ovf);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ovf, res} !== 33'h0) begin
      n_fail++;
      $display("FAIL midreset_async: got ovf=%0b res=%h, want 0/00000000", ovf, res);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({ovf, res} !== 33'h0) begin
      n_fail++;
      $display("FAIL midreset_held: got ovf=%0b res=%h, want 0/00000000", ovf, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (res !== 32'h8000_0000 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: got res=%h ovf=%0b, want res=80000000 ovf=1", res, ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_prev, exp_now;
    logic [31:0] ra, rb;
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
    exp_prev = {ovf, res};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      // Exact latency: previous result still held just before the next edge.
      n_checks++;
      if ({ovf, res} !== exp_prev) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: got ovf=%0b res=%h, want ovf=%0b res=%h",
                 i, ovf, res, exp_prev[32], exp_prev[31:0]);
      end
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_now = model(a, b, cin, sub);
      @(posedge clk); #1;
      n_checks++;
      if ({ovf, res} !== exp_now) begin
        n_fail++;
        $display("FAIL b2b[%0d] a=%h b=%h cin=%0b sub=%0b: got ovf=%0b res=%h, want ovf=%0b res=%h",
                 i, a, b, cin, sub, ovf, res, exp_now[32], exp_now[31:0]);
      end
      exp_prev = exp_now;
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_nocin",   32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b0);
    test_directed("sub_noborrow",32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
    test_directed("add_cin",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    test_directed("sub_borrow",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    test_directed("ovf_pos",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
    test_directed("ovf_neg_sub", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    test_directed("ovf_neg_add", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    test_directed("uwrap_no_ovf",32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    test_directed("ubrw_no_ovf", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    test_mode_change();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
